// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Converts one input bit per clock under a start/busy/done handshake.
// The result feeds a row of BCD-to-7-segment decoders, one per 4-bit digit.
// Optional macro LEADING_ZERO_BLANK_EN enables the registered leading-zero blank mask.
// When that macro is not defined, blank is tied to zero.

module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   // 10^n, wide enough for the largest digit count (10^10 needs 34 bits)
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [BIN_W-1:0]  shreg;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_pend;

   logic [ACC_W-1:0]  acc_adj;
   logic [ACC_W-1:0]  acc_next;

   // Add 3 to every digit >= 5, then shift the next binary bit into the accumulator
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
      acc_next = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_next;

   // Digit i is blanked when it and every digit above it are zero; digit 0 always shows
   always_comb begin : blank_calc
      logic zeros_above;
      zeros_above = 1'b1;
      blank_next  = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zeros_above   = zeros_above & (acc_next[4*i +: 4] == 4'd0);
         blank_next[i] = zeros_above;
      end
   end
`else
   assign blank = '0;
`endif

   // Handshake FSM: capture in IDLE, one shift per clock in SHIFT, one-cycle done pulse in DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         shreg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         blank    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg    <= bin;
                  acc      <= '0;
                  cnt      <= CNT_W'(BIN_W);
                  ovf_pend <= (64'(bin) >= LIMIT);
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               acc   <= acc_next;
               shreg <= shreg << 1;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bcd      <= acc_next;
                  overflow <= ovf_pend;
`ifdef LEADING_ZERO_BLANK_EN
                  blank    <= blank_next;
`endif
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq.
// dut3 uses the default 8-bit / 3-digit build, dut2 uses 2 digits to exercise truncation.
// Expected values come from a decimal arithmetic model of the conversion.

module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start2;
   logic [7:0]  bin, bin2;
   logic        busy, done, overflow;
   logic [11:0] bcd;
   logic [2:0]  blank;
   logic        busy2, done2, overflow2;
   logic [7:0]  bcd2;
   logic [1:0]  blank2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .blank(blank)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2), .blank(blank2)
   );

   // ---------------- reference model ----------------
   function automatic longint p10(input int d);
      longint p = 1;
      for (int k = 0; k < d; k++) p = p * 10;
      return p;
   endfunction

   function automatic logic [39:0] ref_bcd(input longint v, input int d);
      logic [39:0] r = '0;
      longint      x = v % p10(d);
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input longint v, input int d);
      return v >= p10(d);
   endfunction

   function automatic logic [9:0] ref_blank(input longint v, input int d);
      logic [9:0] b = '0;
`ifdef LEADING_ZERO_BLANK_EN
      longint x = v % p10(d);
      for (int i = 1; i < d; i++) b[i] = (x < p10(i));
`endif
      return b;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one conversion on dut3 (sel=0) or dut2 (sel=1); bin is scrambled after capture
   task automatic do_conv(input bit sel, input int v,
                          output logic [39:0] got_bcd, output logic got_ovf,
                          output logic [9:0] got_blank, output int lat,
                          output int bcnt, output logic done_after);
      if (sel) begin start2 = 1'b1; bin2 = 8'(v); end
      else     begin start  = 1'b1; bin  = 8'(v); end
      tick;
      start = 1'b0; start2 = 1'b0;
      bin = 8'($urandom); bin2 = 8'($urandom);
      lat = 0; bcnt = 0;
      while (!(sel ? done2 : done) && lat < 50) begin
         if (sel ? busy2 : busy) bcnt++;
         lat++;
         tick;
      end
      if (lat >= 50) lat = -1;
      got_bcd   = sel ? {32'd0, bcd2} : {28'd0, bcd};
      got_ovf   = sel ? overflow2 : overflow;
      got_blank = sel ? {8'd0, blank2} : {7'd0, blank};
      tick;
      done_after = sel ? done2 : done;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0; start = 0; start2 = 0; bin = 0; bin2 = 0;
      tick; tick;
      vectors++;
      if ({busy, done, bcd, overflow, blank} !== 17'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_dut3: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all 0",
                  busy, done, bcd, overflow, blank);
      end
      vectors++;
      if ({busy2, done2, bcd2, overflow2, blank2} !== 12'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_dut2: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all 0",
                  busy2, done2, bcd2, overflow2, blank2);
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_zero_timing;
      logic [39:0] gb; logic go, da; logic [9:0] gbl; int lat, bc;
      do_conv(0, 0, gb, go, gbl, lat, bc, da);
      vectors++;
      if (lat !== 8) begin miscompares++; $display("[TB] FAIL zero_latency: got %0d want 8", lat); end
      vectors++;
      if (bc !== 8) begin miscompares++; $display("[TB] FAIL zero_busy_cycles: got %0d want 8", bc); end
      vectors++;
      if (gb !== 40'h0 || go !== 1'b0) begin
         miscompares++; $display("[TB] FAIL zero_result: got bcd=%h ovf=%b want 000/0", gb, go);
      end
      vectors++;
      if (da !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_width: done still %b", da); end
   endtask

   task automatic test_directed;
      int vals[3] = '{255, 9, 100};
      logic [39:0] want[3] = '{40'h255, 40'h009, 40'h100};
      logic [39:0] gb; logic go, da; logic [9:0] gbl; int lat, bc;
      foreach (vals[k]) begin
         do_conv(0, vals[k], gb, go, gbl, lat, bc, da);
         vectors++;
         if (gb !== want[k] || go !== 1'b0 || lat !== 8 || da !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL directed_%0d: got bcd=%h ovf=%b lat=%0d done_after=%b want bcd=%h ovf=0 lat=8 done_after=0",
                     vals[k], gb, go, lat, da, want[k]);
         end
      end
   endtask

   task automatic test_digits2;
      logic [39:0] gb; logic go, da; logic [9:0] gbl; int lat, bc;
      do_conv(1, 123, gb, go, gbl, lat, bc, da);
      vectors++;
      if (gb !== 40'h23 || go !== 1'b1) begin
         miscompares++; $display("[TB] FAIL digits2_123: got bcd=%h ovf=%b want 23/1", gb, go);
      end
      do_conv(1, 99, gb, go, gbl, lat, bc, da);
      vectors++;
      if (gb !== 40'h99 || go !== 1'b0) begin
         miscompares++; $display("[TB] FAIL digits2_99: got bcd=%h ovf=%b want 99/0", gb, go);
      end
   endtask

   task automatic test_back_to_back;
      int v, w, n;
      v = int'($urandom_range(0, 255));
      w = int'($urandom_range(0, 255));
      start = 1'b1; bin = 8'(v);
      tick;
      n = 0;
      while (!done && n < 50) begin
         bin = 8'($urandom);
         n++;
         tick;
      end
      vectors++;
      if (n !== 8 || bcd !== ref_bcd(v, 3)) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: got lat=%0d bcd=%h want lat=8 bcd=%h", n, bcd, ref_bcd(v, 3));
      end
      bin = 8'(w);
      n = 0;
      do begin tick; n++; end while (!done && n < 50);
      vectors++;
      if (n !== 10) begin miscompares++; $display("[TB] FAIL b2b_period: got %0d want 10", n); end
      vectors++;
      if (bcd !== ref_bcd(w, 3)) begin
         miscompares++; $display("[TB] FAIL b2b_second: got bcd=%h want %h", bcd, ref_bcd(w, 3));
      end
      start = 1'b0;
      tick; tick;
   endtask

   task automatic test_reset_mid;
      logic [39:0] gb; logic go, da; logic [9:0] gbl; int lat, bc, seen;
      start = 1'b1; bin = 8'd200;
      tick;
      start = 1'b0;
      tick; tick; tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_state: got busy=%b done=%b bcd=%h ovf=%b want 0/0/000/0",
                  busy, done, bcd, overflow);
      end
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         if (done) seen++;
         tick;
      end
      vectors++;
      if (seen !== 0) begin miscompares++; $display("[TB] FAIL midreset_no_done: got %0d pulses want 0", seen); end
      do_conv(0, 42, gb, go, gbl, lat, bc, da);
      vectors++;
      if (gb !== 40'h042 || lat !== 8) begin
         miscompares++; $display("[TB] FAIL midreset_after: got bcd=%h lat=%0d want 042/8", gb, lat);
      end
   endtask

   task automatic test_blank;
      int vals[3] = '{7, 0, 105};
`ifdef LEADING_ZERO_BLANK_EN
      logic [9:0] want[3] = '{10'b110, 10'b110, 10'b000};
`else
      logic [9:0] want[3] = '{10'b000, 10'b000, 10'b000};
`endif
      logic [39:0] gb; logic go, da; logic [9:0] gbl; int lat, bc;
      foreach (vals[k]) begin
         do_conv(0, vals[k], gb, go, gbl, lat, bc, da);
         vectors++;
         if (gbl !== want[k]) begin
            miscompares++; $display("[TB] FAIL blank_%0d: got %b want %b", vals[k], gbl, want[k]);
         end
      end
   endtask

   task automatic test_random;
      logic [39:0] gb; logic go, da; logic [9:0] gbl; int lat, bc, v, d;
      for (int k = 0; k < 60; k++) begin
         bit sel = k[0];
         d = sel ? 2 : 3;
         v = int'($urandom_range(0, 255));
         do_conv(sel, v, gb, go, gbl, lat, bc, da);
         vectors++;
         if (gb !== ref_bcd(v, d) || go !== ref_ovf(v, d) || gbl !== ref_blank(v, d) || lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL random_d%0d_%0d: got bcd=%h ovf=%b blank=%b lat=%0d want bcd=%h ovf=%b blank=%b lat=8",
                     d, v, gb, go, gbl, lat, ref_bcd(v, d), ref_ovf(v, d), ref_blank(v, d));
         end
      end
   endtask

   initial begin
      test_reset;
      test_zero_timing;
      test_directed;
      test_digits2;
      test_back_to_back;
      test_reset_mid;
      test_blank;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
